alu_result_fifo: RTL and testbench
==================================

ALU_RESULT_FIFO -- requirements
Module: alu_result_fifo

Interface
REQ-001 Parameter DEPTH, default 4, FIFO entries; power of two, minimum 2.
REQ-002 Parameter ARITH_WIDTH, default 32, arithmetic result width and stored data width.
REQ-003 Parameter LOGIC_WIDTH / CMP_WIDTH / SHIFT_WIDTH, default 16 each, unit result widths; each SHALL be no greater than ARITH_WIDTH.
REQ-004 One clock; reset is synchronous and active-high. CLK  in  1  clock, all logic on rising edge.
REQ-005 RST  in  1  synchronous active-high reset.
REQ-006 Arith_OUT / Carry_OUT / Arith_Flag  in  ARITH_WIDTH/1/1  arithmetic unit result, carry, valid.
REQ-007 Logic_OUT / Logic_Flag  in  LOGIC_WIDTH/1  logic unit result, valid.
REQ-008 CMP_OUT / CMP_Flag  in  CMP_WIDTH/1  compare unit result, valid.
REQ-009 Shift_OUT / Shift_Flag  in  SHIFT_WIDTH/1  shift unit result, valid.
REQ-010 RES_READY  in  1  consumer accepts head entry.
REQ-011 CLR_ERR  in  1  clears sticky error flags.
REQ-012 RES_VALID  out  1  head entry present.
REQ-013 RES_DATA / RES_CLASS / RES_CARRY  out  ARITH_WIDTH/2/1  head entry data, unit class, carry.
REQ-014 FULL / EMPTY  out  1/1  occupancy status; COUNT  out  log2(DEPTH)+1  entries held.
REQ-015 OVF_ERR / MULTI_ERR  out  1/1  sticky overflow and multiple-flag errors.

Function
REQ-016 Push request: any input flag high in a cycle; entry = {class, carry, data zero-extended to ARITH_WIDTH}.
REQ-017 Class codes: Arith 2'b00, Logic 2'b01, CMP 2'b10, Shift 2'b11; carry stored only for Arith, else 0.
REQ-018 More than one flag high: push only highest priority (Arith > Logic > CMP > Shift), set MULTI_ERR.
REQ-019 Pop: RES_VALID and RES_READY both high at rising edge; head advances.
REQ-020 Show-ahead output: RES_DATA/RES_CLASS/RES_CARRY reflect head entry whenever RES_VALID; all three SHALL be 0 when EMPTY.
REQ-021 Latency: entry pushed at edge N visible with RES_VALID=1 after edge N; no combinational flag-to-output path.
REQ-022 Push while FULL without pop: entry dropped, contents unchanged, OVF_ERR set.
REQ-023 Push while FULL with pop in same cycle: push accepted, COUNT unchanged.
REQ-024 Push and pop in same cycle when not empty: both performed, COUNT unchanged; push while EMPTY: no pop possible, COUNT becomes 1.
REQ-025 Read/write pointers wrap from DEPTH-1 to 0; COUNT never exceeds DEPTH nor underflows.
REQ-026 FULL = (COUNT == DEPTH), EMPTY = (COUNT == 0), RES_VALID = !EMPTY.
REQ-027 CLR_ERR clears OVF_ERR and MULTI_ERR; error event in same cycle as CLR_ERR wins (flag set).

Reset
REQ-028 RST high at edge: pointers and COUNT = 0, EMPTY=1, FULL=0, RES_VALID=0, RES_DATA/RES_CLASS/RES_CARRY=0, OVF_ERR=MULTI_ERR=0.
REQ-029 RST dominates push, pop and CLR_ERR in same cycle; entries in flight mid-operation are discarded; storage array needs no reset.

Configuration
REQ-030 Macro ALU_RES_PARITY_EN defined: each entry stores even-parity bit over {class, carry, data}; extra output RES_PARITY (1 bit) shows head parity, 0 when EMPTY or in reset.
REQ-031 Macro undefined: no parity storage, no RES_PARITY port; all other behaviour identical.

Structure
REQ-032 Shared package alu_res_pkg holds class code constants, priority encoding, entry field widths/offsets.
REQ-033 Single sub-module alu_res_mem: DEPTH x entry-width register array, one write port, one asynchronous read port; control, pointers and flags live in alu_result_fifo.

Verification
REQ-034 Reset then Arith_Flag=1, Arith_OUT=32'h0001_0005, Carry_OUT=1 -> next cycle RES_VALID=1, RES_DATA=32'h0001_0005, RES_CLASS=0, RES_CARRY=1, COUNT=1.
REQ-035 Logic_Flag=1, Logic_OUT=16'hFFFF with Carry_OUT=1 -> RES_DATA=32'h0000_FFFF, RES_CLASS=1, RES_CARRY=0.
REQ-036 RES_READY=0, 5 consecutive CMP pushes (DEPTH=4) -> FULL=1, COUNT=4, OVF_ERR=1, fifth value absent from drained sequence.
REQ-037 FULL, then push Shift 16'h0003 with RES_READY=1 same cycle -> COUNT stays 4, OVF_ERR stays 0, drained order preserved, pointers wrap correctly over 10 entries.
REQ-038 Arith_Flag=1 and Shift_Flag=1 together -> single Arith entry, MULTI_ERR=1; CLR_ERR pulse -> MULTI_ERR=0.
REQ-039 RST asserted with COUNT=3 and push pending -> next cycle EMPTY=1, COUNT=0, outputs 0, errors 0.

Source files
------------

// File: rtl/alu_res_pkg.sv
// Shared definitions for the ALU result FIFO: unit class codes, the
// flag priority encoder and the field layout of a stored entry.
package alu_res_pkg;

    typedef enum logic [1:0] {
        CLASS_ARITH = 2'b00,
        CLASS_LOGIC = 2'b01,
        CLASS_CMP   = 2'b10,
        CLASS_SHIFT = 2'b11
    } res_class_t;

    localparam int CLASS_W  = 2;
    localparam int CARRY_W  = 1;
    localparam int DATA_LSB = 0;

    // Entry layout, LSB first: data | carry | class (| parity on top when enabled).
    function automatic int carry_pos(input int arith_width);
        return arith_width;
    endfunction

    function automatic int class_lsb(input int arith_width);
        return arith_width + CARRY_W;
    endfunction

    function automatic int payload_width(input int arith_width);
        return arith_width + CARRY_W + CLASS_W;
    endfunction

    // flags = {arith, logic, cmp, shift}; highest priority wins.
    function automatic res_class_t prio_class(input logic [3:0] flags);
        if (flags[3])      return CLASS_ARITH;
        else if (flags[2]) return CLASS_LOGIC;
        else if (flags[1]) return CLASS_CMP;
        else if (flags[0]) return CLASS_SHIFT;
        else               return CLASS_ARITH;
    endfunction

    function automatic logic multi_flag(input logic [3:0] flags);
        return (flags & (flags - 4'd1)) != 4'd0;
    endfunction

endpackage

// File: rtl/alu_res_mem.sv
// Entry storage for the ALU result FIFO: register array with one
// synchronous write port and one asynchronous read port; no reset needed.
module alu_res_mem #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 35
) (
    input  logic                     CLK,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/alu_result_fifo.sv
// Show-ahead FIFO collecting results from four ALU units with sticky error flags.
// Optional per-entry even parity and RES_PARITY output under `ALU_RES_PARITY_EN.
module alu_result_fifo
    import alu_res_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int ARITH_WIDTH = 32,
    parameter int LOGIC_WIDTH = 16,
    parameter int CMP_WIDTH   = 16,
    parameter int SHIFT_WIDTH = 16
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [ARITH_WIDTH-1:0]   Arith_OUT,
    input  logic                     Carry_OUT,
    input  logic                     Arith_Flag,
    input  logic [LOGIC_WIDTH-1:0]   Logic_OUT,
    input  logic                     Logic_Flag,
    input  logic [CMP_WIDTH-1:0]     CMP_OUT,
    input  logic                     CMP_Flag,
    input  logic [SHIFT_WIDTH-1:0]   Shift_OUT,
    input  logic                     Shift_Flag,
    input  logic                     RES_READY,
    input  logic                     CLR_ERR,
    output logic                     RES_VALID,
    output logic [ARITH_WIDTH-1:0]   RES_DATA,
    output logic [1:0]               RES_CLASS,
    output logic                     RES_CARRY,
    output logic                     FULL,
    output logic                     EMPTY,
    output logic [$clog2(DEPTH):0]   COUNT,
    output logic                     OVF_ERR,
    output logic                     MULTI_ERR
`ifdef ALU_RES_PARITY_EN
    ,
    output logic                     RES_PARITY
`endif
);

    localparam int AW        = $clog2(DEPTH);
    localparam int CW        = AW + 1;
    localparam int CARRY_POS = carry_pos(ARITH_WIDTH);
    localparam int CLASS_LSB = class_lsb(ARITH_WIDTH);
    localparam int PAYLOAD_W = payload_width(ARITH_WIDTH);
`ifdef ALU_RES_PARITY_EN
    localparam int ENTRY_W   = PAYLOAD_W + 1;
`else
    localparam int ENTRY_W   = PAYLOAD_W;
`endif

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("alu_result_fifo: DEPTH must be a power of two and at least 2");
    end
    if ((LOGIC_WIDTH > ARITH_WIDTH) || (CMP_WIDTH > ARITH_WIDTH) ||
        (SHIFT_WIDTH > ARITH_WIDTH)) begin : g_bad_width
        $error("alu_result_fifo: unit widths must not exceed ARITH_WIDTH");
    end

    logic [3:0]             flags;
    res_class_t             sel_class;
    logic [ARITH_WIDTH-1:0] sel_data;
    logic                   sel_carry;
    logic [PAYLOAD_W-1:0]   wr_payload;
    logic [ENTRY_W-1:0]     wr_entry;
    logic [ENTRY_W-1:0]     rd_entry;

    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [CW-1:0]          count;
    logic                   full;
    logic                   empty;
    logic                   push_req;
    logic                   pop;
    logic                   push_ok;
    logic                   ovf_evt;
    logic                   multi_evt;

    assign flags = {Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag};

    always_comb begin
        sel_class = prio_class(flags);
        sel_data  = '0;
        sel_carry = 1'b0;
        case (sel_class)
            CLASS_ARITH: begin
                sel_data  = Arith_OUT;
                sel_carry = Carry_OUT;
            end
            CLASS_LOGIC: sel_data = ARITH_WIDTH'(Logic_OUT);
            CLASS_CMP:   sel_data = ARITH_WIDTH'(CMP_OUT);
            CLASS_SHIFT: sel_data = ARITH_WIDTH'(Shift_OUT);
            default:     sel_data = '0;
        endcase
    end

    assign wr_payload = {sel_class, sel_carry, sel_data};
`ifdef ALU_RES_PARITY_EN
    assign wr_entry = {^wr_payload, wr_payload};
`else
    assign wr_entry = wr_payload;
`endif

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign push_req  = |flags;
    assign pop       = !empty && RES_READY;
    // A full FIFO still takes a new entry when the head leaves in the same cycle.
    assign push_ok   = push_req && (!full || pop);
    assign ovf_evt   = push_req && full && !pop;
    assign multi_evt = multi_flag(flags);

    alu_res_mem #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_mem (
        .CLK   (CLK),
        .we    (push_ok && !RST),
        .waddr (wr_ptr),
        .wdata (wr_entry),
        .raddr (rd_ptr),
        .rdata (rd_entry)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            OVF_ERR   <= 1'b0;
            MULTI_ERR <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            // A new error event outranks a clear in the same cycle.
            OVF_ERR   <= ovf_evt   || (OVF_ERR   && !CLR_ERR);
            MULTI_ERR <= multi_evt || (MULTI_ERR && !CLR_ERR);
        end
    end

    assign COUNT     = count;
    assign FULL      = full;
    assign EMPTY     = empty;
    assign RES_VALID = !empty;
    assign RES_DATA  = empty ? '0   : rd_entry[ARITH_WIDTH-1:0];
    assign RES_CARRY = empty ? 1'b0 : rd_entry[CARRY_POS];
    assign RES_CLASS = empty ? 2'b0 : rd_entry[CLASS_LSB +: CLASS_W];
`ifdef ALU_RES_PARITY_EN
    assign RES_PARITY = (empty || RST) ? 1'b0 : rd_entry[ENTRY_W-1];
`endif

endmodule

// File: tb/tb_alu_result_fifo.sv
// Directed self-checking bench for alu_result_fifo (DEPTH=4, default widths).
`timescale 1ns/1ps
module tb_alu_result_fifo;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] Arith_OUT;
    logic        Carry_OUT, Arith_Flag;
    logic [15:0] Logic_OUT, CMP_OUT, Shift_OUT;
    logic        Logic_Flag, CMP_Flag, Shift_Flag;
    logic        RES_READY, CLR_ERR;
    logic        RES_VALID;
    logic [31:0] RES_DATA;
    logic [1:0]  RES_CLASS;
    logic        RES_CARRY, FULL, EMPTY, OVF_ERR, MULTI_ERR;
    logic [2:0]  COUNT;
`ifdef ALU_RES_PARITY_EN
    logic        RES_PARITY;
`endif

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] q[$];

    always #5 CLK = ~CLK;

    alu_result_fifo #(.DEPTH(4)) dut (
        .CLK(CLK), .RST(RST),
        .Arith_OUT(Arith_OUT), .Carry_OUT(Carry_OUT), .Arith_Flag(Arith_Flag),
        .Logic_OUT(Logic_OUT), .Logic_Flag(Logic_Flag),
        .CMP_OUT(CMP_OUT), .CMP_Flag(CMP_Flag),
        .Shift_OUT(Shift_OUT), .Shift_Flag(Shift_Flag),
        .RES_READY(RES_READY), .CLR_ERR(CLR_ERR),
        .RES_VALID(RES_VALID), .RES_DATA(RES_DATA), .RES_CLASS(RES_CLASS),
        .RES_CARRY(RES_CARRY), .FULL(FULL), .EMPTY(EMPTY), .COUNT(COUNT),
        .OVF_ERR(OVF_ERR), .MULTI_ERR(MULTI_ERR)
`ifdef ALU_RES_PARITY_EN
        , .RES_PARITY(RES_PARITY)
`endif
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        Arith_OUT = '0; Carry_OUT = 0; Arith_Flag = 0;
        Logic_OUT = '0; Logic_Flag = 0;
        CMP_OUT = '0; CMP_Flag = 0;
        Shift_OUT = '0; Shift_Flag = 0;
        RES_READY = 0; CLR_ERR = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        RST = 1;
        tick();
        RST = 0;
        n_vec++; if (EMPTY !== 1'b1) begin n_err++; $display("FAIL reset_empty got %b want 1", EMPTY); end
        n_vec++; if (FULL !== 1'b0) begin n_err++; $display("FAIL reset_full got %b want 0", FULL); end
        n_vec++; if (RES_VALID !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", RES_VALID); end
        n_vec++; if (COUNT !== 3'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", COUNT); end
        n_vec++; if ({RES_DATA, RES_CLASS, RES_CARRY} !== 35'h0) begin n_err++; $display("FAIL reset_outputs got %h/%0d/%b want 0", RES_DATA, RES_CLASS, RES_CARRY); end
        n_vec++; if ({OVF_ERR, MULTI_ERR} !== 2'b00) begin n_err++; $display("FAIL reset_errors got %b%b want 00", OVF_ERR, MULTI_ERR); end
    endtask

    task automatic test_arith_push();
        Arith_Flag = 1; Arith_OUT = 32'h0001_0005; Carry_OUT = 1;
        tick();
        idle_inputs();
        n_vec++; if (RES_VALID !== 1'b1) begin n_err++; $display("FAIL arith_valid got %b want 1", RES_VALID); end
        n_vec++; if (RES_DATA !== 32'h0001_0005) begin n_err++; $display("FAIL arith_data got %h want 00010005", RES_DATA); end
        n_vec++; if (RES_CLASS !== 2'd0) begin n_err++; $display("FAIL arith_class got %0d want 0", RES_CLASS); end
        n_vec++; if (RES_CARRY !== 1'b1) begin n_err++; $display("FAIL arith_carry got %b want 1", RES_CARRY); end
        n_vec++; if (COUNT !== 3'd1) begin n_err++; $display("FAIL arith_count got %0d want 1", COUNT); end
`ifdef ALU_RES_PARITY_EN
        n_vec++; if (RES_PARITY !== 1'b0) begin n_err++; $display("FAIL arith_parity got %b want 0", RES_PARITY); end
`endif
        RES_READY = 1;
        tick();
        RES_READY = 0;
        n_vec++; if (EMPTY !== 1'b1 || RES_DATA !== 32'h0) begin n_err++; $display("FAIL arith_pop got empty=%b data=%h want 1/0", EMPTY, RES_DATA); end
    endtask

    task automatic test_logic_push();
        Logic_Flag = 1; Logic_OUT = 16'hFFFF; Carry_OUT = 1;
        tick();
        idle_inputs();
        n_vec++; if (RES_DATA !== 32'h0000_FFFF) begin n_err++; $display("FAIL logic_data got %h want 0000ffff", RES_DATA); end
        n_vec++; if (RES_CLASS !== 2'd1) begin n_err++; $display("FAIL logic_class got %0d want 1", RES_CLASS); end
        n_vec++; if (RES_CARRY !== 1'b0) begin n_err++; $display("FAIL logic_carry got %b want 0", RES_CARRY); end
        RES_READY = 1;
        tick();
        RES_READY = 0;
        n_vec++; if (COUNT !== 3'd0) begin n_err++; $display("FAIL logic_pop_count got %0d want 0", COUNT); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 5; i++) begin
            CMP_Flag = 1; CMP_OUT = 16'h0010 + 16'(i);
            tick();
            if (i == 3) begin
                n_vec++; if (OVF_ERR !== 1'b0) begin n_err++; $display("FAIL ovf_early got %b want 0", OVF_ERR); end
            end
        end
        idle_inputs();
        n_vec++; if (FULL !== 1'b1) begin n_err++; $display("FAIL ovf_full got %b want 1", FULL); end
        n_vec++; if (COUNT !== 3'd4) begin n_err++; $display("FAIL ovf_count got %0d want 4", COUNT); end
        n_vec++; if (OVF_ERR !== 1'b1) begin n_err++; $display("FAIL ovf_flag got %b want 1", OVF_ERR); end
        RES_READY = 1;
        for (int i = 0; i < 4; i++) begin
            n_vec++; if (RES_DATA !== 32'h10 + 32'(i) || RES_CLASS !== 2'd2) begin n_err++; $display("FAIL ovf_drain%0d got %h/%0d want %h/2", i, RES_DATA, RES_CLASS, 32'h10 + 32'(i)); end
            tick();
        end
        RES_READY = 0;
        n_vec++; if (EMPTY !== 1'b1) begin n_err++; $display("FAIL ovf_drained_empty got %b want 1", EMPTY); end
        CLR_ERR = 1;
        tick();
        CLR_ERR = 0;
        n_vec++; if (OVF_ERR !== 1'b0) begin n_err++; $display("FAIL ovf_clear got %b want 0", OVF_ERR); end
    endtask

    task automatic test_back_to_back();
        q.delete();
        for (int i = 0; i < 4; i++) begin
            Shift_Flag = 1; Shift_OUT = 16'h00A0 + 16'(i); Carry_OUT = 1;
            q.push_back(32'h00A0 + 32'(i));
            tick();
        end
        n_vec++; if (FULL !== 1'b1) begin n_err++; $display("FAIL b2b_full got %b want 1", FULL); end
        RES_READY = 1;
        for (int k = 0; k < 6; k++) begin
            Shift_OUT = 16'h0003 + 16'(k);
            n_vec++; if (RES_DATA !== q[0]) begin n_err++; $display("FAIL b2b_head%0d got %h want %h", k, RES_DATA, q[0]); end
            tick();
            void'(q.pop_front());
            q.push_back(32'h0003 + 32'(k));
            n_vec++; if (COUNT !== 3'd4 || OVF_ERR !== 1'b0) begin n_err++; $display("FAIL b2b_count%0d got %0d ovf=%b want 4 ovf=0", k, COUNT, OVF_ERR); end
        end
        Shift_Flag = 0;
        for (int i = 0; i < 4; i++) begin
            n_vec++; if (RES_DATA !== q[0] || RES_CLASS !== 2'd3 || RES_CARRY !== 1'b0) begin n_err++; $display("FAIL b2b_drain%0d got %h/%0d/%b want %h/3/0", i, RES_DATA, RES_CLASS, RES_CARRY, q[0]); end
            tick();
            void'(q.pop_front());
        end
        idle_inputs();
        n_vec++; if (EMPTY !== 1'b1) begin n_err++; $display("FAIL b2b_empty got %b want 1", EMPTY); end
        // Push and pop requested while empty: only the push happens.
        Arith_Flag = 1; Arith_OUT = 32'h5A5A_0001; RES_READY = 1;
        tick();
        idle_inputs();
        n_vec++; if (COUNT !== 3'd1 || RES_DATA !== 32'h5A5A_0001) begin n_err++; $display("FAIL empty_pushpop got %0d/%h want 1/5a5a0001", COUNT, RES_DATA); end
        RES_READY = 1;
        tick();
        RES_READY = 0;
    endtask

    task automatic test_multi();
        Arith_Flag = 1; Arith_OUT = 32'hDEAD_BEEF; Shift_Flag = 1; Shift_OUT = 16'h1234;
        tick();
        idle_inputs();
        n_vec++; if (COUNT !== 3'd1) begin n_err++; $display("FAIL multi_count got %0d want 1", COUNT); end
        n_vec++; if (RES_DATA !== 32'hDEAD_BEEF || RES_CLASS !== 2'd0) begin n_err++; $display("FAIL multi_entry got %h/%0d want deadbeef/0", RES_DATA, RES_CLASS); end
        n_vec++; if (MULTI_ERR !== 1'b1) begin n_err++; $display("FAIL multi_flag got %b want 1", MULTI_ERR); end
        RES_READY = 1; CLR_ERR = 1;
        tick();
        idle_inputs();
        n_vec++; if (MULTI_ERR !== 1'b0 || EMPTY !== 1'b1) begin n_err++; $display("FAIL multi_clear got %b empty=%b want 0/1", MULTI_ERR, EMPTY); end
        Logic_Flag = 1; Logic_OUT = 16'h00C3; CMP_Flag = 1; CMP_OUT = 16'h0077; CLR_ERR = 1;
        tick();
        idle_inputs();
        n_vec++; if (MULTI_ERR !== 1'b1) begin n_err++; $display("FAIL multi_vs_clear got %b want 1", MULTI_ERR); end
        n_vec++; if (RES_DATA !== 32'h0000_00C3 || RES_CLASS !== 2'd1) begin n_err++; $display("FAIL multi_logic got %h/%0d want 000000c3/1", RES_DATA, RES_CLASS); end
        RES_READY = 1; CLR_ERR = 1;
        tick();
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        Arith_Flag = 1; Arith_OUT = 32'h111;
        tick();
        idle_inputs(); Logic_Flag = 1; Logic_OUT = 16'h222;
        tick();
        idle_inputs(); CMP_Flag = 1; CMP_OUT = 16'h333; Shift_Flag = 1;
        tick();
        idle_inputs();
        n_vec++; if (COUNT !== 3'd3 || MULTI_ERR !== 1'b1) begin n_err++; $display("FAIL rstmid_setup got %0d/%b want 3/1", COUNT, MULTI_ERR); end
        RST = 1; Arith_Flag = 1; Arith_OUT = 32'h444; RES_READY = 1;
        tick();
        RST = 0;
        idle_inputs();
        n_vec++; if (EMPTY !== 1'b1 || COUNT !== 3'd0 || RES_VALID !== 1'b0) begin n_err++; $display("FAIL rstmid_state got empty=%b count=%0d valid=%b want 1/0/0", EMPTY, COUNT, RES_VALID); end
        n_vec++; if ({RES_DATA, RES_CLASS, RES_CARRY} !== 35'h0) begin n_err++; $display("FAIL rstmid_outputs got %h want 0", {RES_DATA, RES_CLASS, RES_CARRY}); end
        n_vec++; if ({OVF_ERR, MULTI_ERR} !== 2'b00) begin n_err++; $display("FAIL rstmid_errors got %b%b want 00", OVF_ERR, MULTI_ERR); end
        tick();
        n_vec++; if (COUNT !== 3'd0) begin n_err++; $display("FAIL rstmid_hold got %0d want 0", COUNT); end
    endtask

    initial begin
        RST = 1;
        idle_inputs();
        test_reset();
        test_arith_push();
        test_logic_push();
        test_overflow();
        test_back_to_back();
        test_multi();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
